// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the iterative round engine and its
// combinational round stage.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit 2047-8b, which is {~b, 3'b111} in 11 bits.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int unsigned byte_msb(input int unsigned row, input int unsigned col);
        return 127 - 8 * (4 * col + row);
    endfunction

    function automatic bit nr_legal(input int nr);
        return (nr == 10) || (nr == 12) || (nr == 14);
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One AES encryption round (SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey) as pure combinational logic.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] key,
    input  logic         final_round,
    output logic [127:0] next_st
);

    logic [127:0] sr;
    logic [127:0] mc;

    always_comb begin
        sr = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[byte_msb(r, c) -: 8] = sbox(st[byte_msb(r, (c + r) % 4) -: 8]);
            end
        end
    end

    // Row r of each output column: 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
    always_comb begin
        mc = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                mc[byte_msb(r, c) -: 8] = xtime(sr[byte_msb(r, c) -: 8])
                                        ^ xtime(sr[byte_msb((r + 1) % 4, c) -: 8])
                                        ^ sr[byte_msb((r + 1) % 4, c) -: 8]
                                        ^ sr[byte_msb((r + 2) % 4, c) -: 8]
                                        ^ sr[byte_msb((r + 3) % 4, c) -: 8];
            end
        end
    end

    assign next_st = (final_round ? sr : mc) ^ key;

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: initial AddRoundKey on accept, then NR
// rounds through one shared round stage, keys fetched by key_idx.
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NR  = 10,
    parameter int KIW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    output logic [KIW-1:0] key_idx,
    input  logic [127:0]   key_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data
);

    if (!nr_legal(NR)) begin : g_bad_nr
        $error("aes_round_engine: NR=%0d must be 10, 12 or 14", NR);
    end
    if ((64'd1 << KIW) <= 64'(NR)) begin : g_bad_kiw
        $error("aes_round_engine: KIW=%0d too narrow for NR=%0d", KIW, NR);
    end

    localparam logic [KIW-1:0] LAST_RC = KIW'(NR);

    state_t         state;
    logic [KIW-1:0] rc;
    logic [127:0]   st;
    logic [127:0]   round_st;
    logic           last_round;

    assign last_round = (rc == LAST_RC);

    aes_round_comb u_round (
        .st          (st),
        .key         (key_in),
        .final_round (last_round),
        .next_st     (round_st)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rc    <= '0;
            st    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= in_data ^ key_in;
                        rc    <= KIW'(1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    st <= round_st;
                    if (last_round) begin
                        state <= DONE;
                    end else begin
                        rc <= rc + KIW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        rc    <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode only the state register, so key_idx never depends on key_in.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = (state == DONE) ? st : '0;
    assign key_idx   = (state == RUN) ? rc : '0;

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: FIPS-197 vectors on NR=10/12/14
// instances, backpressure, ignored in_valid, back-to-back and mid-run reset.
module tb_aes_round_engine;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         out_ready;
    logic [127:0] in_data;
    logic         iv  [3];
    logic         ir  [3];
    logic [3:0]   ki  [3];
    logic [127:0] kin [3];
    logic         ov  [3];
    logic [127:0] od  [3];
    logic [127:0] rk  [3][16];

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    assign kin[0] = rk[0][ki[0]];
    assign kin[1] = rk[1][ki[1]];
    assign kin[2] = rk[2][ki[2]];

    aes_round_engine #(.NR(10), .KIW(4)) u_aes128 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
        .key_idx(ki[0]), .key_in(kin[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]));

    aes_round_engine #(.NR(12), .KIW(4)) u_aes192 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
        .key_idx(ki[1]), .key_in(kin[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]));

    aes_round_engine #(.NR(14), .KIW(4)) u_aes256 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
        .key_idx(ki[2]), .key_in(kin[2]), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]));

    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PTB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KB   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // FIPS-197 key expansion into the key store of instance d.
    task automatic expand(input int d, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int          nr;
        nr   = nk + 6;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one block, follows it through every round and holds DONE for
    // 'hold' extra cycles; with noise, in_valid stays high while busy.
    task automatic encrypt(input int d, input logic [127:0] pt, input logic [127:0] ct,
                           input int nr, input int hold, input bit noise, input string tag);
        in_data = pt;
        iv[d]   = 1'b1;
        check({tag, " in_ready idle"}, 128'(ir[d]), 128'(1));
        check({tag, " key_idx idle"}, 128'(ki[d]), 128'(0));
        step();
        if (!noise) iv[d] = 1'b0;
        for (int k = 1; k <= nr; k++) begin
            check({tag, " key_idx run"}, 128'(ki[d]), 128'(k));
            check({tag, " in_ready run"}, 128'(ir[d]), 128'(0));
            check({tag, " out_valid run"}, 128'(ov[d]), 128'(0));
            step();
        end
        for (int h = 0; h <= hold; h++) begin
            check({tag, " out_valid done"}, 128'(ov[d]), 128'(1));
            check({tag, " out_data"}, od[d], ct);
            check({tag, " in_ready done"}, 128'(ir[d]), 128'(0));
            if (h == hold) out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        iv[d]     = 1'b0;
        check({tag, " out_valid after"}, 128'(ov[d]), 128'(0));
        check({tag, " in_ready after"}, 128'(ir[d]), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, %0d tests run", ntests);
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        in_data   = '0;
        for (int d = 0; d < 3; d++) iv[d] = 1'b0;
        for (int d = 0; d < 3; d++) for (int r = 0; r < 16; r++) rk[d][r] = '0;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            check("reset in_ready", 128'(ir[d]), 128'(1));
            check("reset out_valid", 128'(ov[d]), 128'(0));
            check("reset out_data", od[d], 128'(0));
            check("reset key_idx", 128'(ki[d]), 128'(0));
        end
        rst = 1'b0;
        step();

        expand(0, K128, 4);
        encrypt(0, PT1, CT1, 10, 0, 1'b0, "aes128_c1");

        expand(0, KB, 4);
        encrypt(0, PTB, CTB, 10, 5, 1'b1, "aes128_appb_bp");
        expand(0, K128, 4);
        encrypt(0, PT1, CT1, 10, 0, 1'b0, "aes128_b2b");

        expand(1, K192, 6);
        encrypt(1, PT1, CT2, 12, 0, 1'b0, "aes192_c2");

        expand(2, K256, 8);
        encrypt(2, PT1, CT3, 14, 2, 1'b1, "aes256_c3");

        // Reset during round 4 with in_valid and out_ready also high.
        in_data = PT1;
        iv[0]   = 1'b1;
        step();
        iv[0] = 1'b0;
        repeat (3) step();
        check("rst pre key_idx", 128'(ki[0]), 128'(4));
        rst       = 1'b1;
        iv[0]     = 1'b1;
        out_ready = 1'b1;
        step();
        check("rst in_ready", 128'(ir[0]), 128'(1));
        check("rst out_valid", 128'(ov[0]), 128'(0));
        check("rst key_idx", 128'(ki[0]), 128'(0));
        check("rst out_data", od[0], 128'(0));
        rst       = 1'b0;
        iv[0]     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("rst no output", 128'(ov[0]), 128'(0));
            step();
        end
        expand(0, KB, 4);
        encrypt(0, PTB, CTB, 10, 1, 1'b0, "aes128_post_rst");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
